config_frame_writer: RTL
========================

Name: config_frame_writer

Overview:
- Bitstream-side producer of the frame-configuration interface that drives tile ConfigBits latches, such as the MUX8LUT primitive's 2 bits.
- Accepts a stream of 32-bit configuration words through a valid/ready handshake and decodes sync, command and data words.
- Assembles one frame of NumberOfRows x 32 bits and issues a single-cycle one-hot FrameStrobe to the addressed column/frame latch.
- Sits between the bitstream source (UART/SPI/host loader) and the fabric's FrameData/FrameStrobe distribution.

Parameters:
NumberOfRows, 4, rows per column; each row receives one 32-bit frame word.
NumberOfCols, 4, fabric columns.
MaxFramesPerCol, 20, frame latches per column.
SyncWord, 32'hFAB0_FAB1, word that enables command decoding.

Ports:
CLK  input  1  fabric configuration clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
WordData  input  32  configuration word.
WordValid  input  1  WordData valid this cycle.
WordReady  output  1  writer accepts WordData this cycle; transfer = WordValid & WordReady.
FrameData  output  32*NumberOfRows  assembled frame; row r in bits [32r+31:32r].
FrameStrobe  output  NumberOfCols*MaxFramesPerCol  one-hot latch strobe; bit index = col*MaxFramesPerCol+frame.
Synced  output  1  sync word received, command decoding active.
AddrError  output  1  sticky: a WRITE_FRAME carried an out-of-range column or frame.
Busy  output  1  high in DATA, STROBE and HOLD.

Behaviour:
- Interface: one clock (CLK); synchronous active-high reset (reset).
- Reset values: FSM=UNSYNC, FrameData=0, FrameStrobe=0, Synced=0, AddrError=0, WordReady=1, Busy=0.
- Command word format when Synced:
  - [31:28]=4'h1: WRITE_FRAME; [27:20]=column, [19:12]=frame index, [11:0] ignored.
  - [31:28]=4'hF: DESYNC.
  - Any other opcode, including a repeated SyncWord: NOP, consumed without effect.
- UNSYNC:
  - WordReady=1; every word is consumed.
  - SyncWord -> CMD and Synced=1 from the next cycle. Any other word is dropped.
- CMD:
  - WordReady=1.
  - WRITE_FRAME latches col/frame, clears row counter -> DATA.
  - WRITE_FRAME with col>=NumberOfCols or frame>=MaxFramesPerCol also sets AddrError and latches a discard flag.
  - DESYNC -> UNSYNC, Synced=0 next cycle.
- DATA:
  - WordReady=1. Each transfer writes FrameData row[rowcnt] and increments rowcnt.
  - The transfer with rowcnt==NumberOfRows-1 -> STROBE (no discard) or CMD (discard).
  - Rows not yet written keep their previous values.
- STROBE:
  - Exactly one cycle; WordReady=0.
  - FrameStrobe has only bit col*MaxFramesPerCol+frame set -> HOLD.
- HOLD:
  - One cycle; WordReady=0, FrameStrobe=0, FrameData unchanged (hold time for tile latches) -> CMD.
- Latency: last data word accepted at edge N; FrameStrobe high in cycle N+1; next word accepted no earlier than edge N+3.
- FrameData changes only on DATA transfers; it is stable from the last data word through HOLD.
- FrameStrobe is all-zero in every state except STROBE. It is never multi-hot.
- WordValid low stalls any state except STROBE/HOLD, with no timeout. Data words are never interpreted as commands.
- AddrError is cleared only by reset; DESYNC does not clear it.
- reset mid-frame:
  - Next cycle returns to reset values, FrameStrobe forced 0, partial frame abandoned.
  - A reset coinciding with STROBE suppresses the strobe in that same cycle.
- Index arithmetic: col*MaxFramesPerCol+frame is computed at width clog2(NumberOfCols*MaxFramesPerCol). The range check uses the full 8-bit fields before truncation.

Test Plan:
- Reset, then feed 0x1234_5678 while UNSYNC -> dropped; Synced=0, FrameStrobe=0, WordReady=1.
- SyncWord, then 0x1020_3000 (col 2, frame 3), then data words 0xA0000000..0xA0000003 back-to-back:
  - FrameData={0xA0000003,0xA0000002,0xA0000001,0xA0000000}.
  - FrameStrobe bit 43 high for exactly one cycle, one cycle after the 4th word.
  - WordReady=0 for 2 cycles.
- WRITE_FRAME col 4 (0x1040_0000) plus 4 data words -> AddrError=1 and stays set; no FrameStrobe bit ever set. The next valid frame (col 0, frame 19 -> bit 19) strobes normally.
- Random WordValid gaps (50%) across two frames -> identical FrameData/strobe results to the back-to-back case; no word lost or duplicated.
- After 2 data words assert reset -> all outputs at reset values next cycle. SyncWord plus a full frame afterward produces the correct strobe.
- DESYNC 0xF000_0000 -> Synced=0. Subsequent 0x1000_0000 plus data -> treated as unsynced garbage, no strobe.

Source files
------------

// File: rtl/config_frame_writer.sv
// Frame-configuration writer: decodes sync/command/data words from a valid/ready
// stream, assembles one frame of NumberOfRows x 32 bits and pulses a one-hot FrameStrobe.
module config_frame_writer #(
  parameter int unsigned NumberOfRows    = 4,
  parameter int unsigned NumberOfCols    = 4,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [31:0]                             WordData,
  input  logic                                    WordValid,
  output logic                                    WordReady,
  output logic [32*NumberOfRows-1:0]              FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    Synced,
  output logic                                    AddrError,
  output logic                                    Busy
);

  localparam int unsigned FRAME_W = 32 * NumberOfRows;
  localparam int unsigned STRB_W  = NumberOfCols * MaxFramesPerCol;
  localparam int unsigned IDX_W   = (STRB_W > 1) ? $clog2(STRB_W) : 1;
  localparam int unsigned ROW_W   = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  localparam logic [2:0] S_UNSYNC = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               discard_q, discard_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [STRB_W-1:0]  strobe_q, strobe_d;
  logic               synced_q, synced_d;
  logic               addr_err_q, addr_err_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               transfer;
  logic [3:0]         opcode;
  logic [7:0]         cmd_col;
  logic [7:0]         cmd_frame;
  logic               out_of_range;

  assign transfer     = WordValid & ready_q;
  assign opcode       = WordData[31:28];
  assign cmd_col      = WordData[27:20];
  assign cmd_frame    = WordData[19:12];
  // Range check on the full 8-bit fields, before any truncation into the index.
  assign out_of_range = (32'(cmd_col) >= NumberOfCols) || (32'(cmd_frame) >= MaxFramesPerCol);

  // State register and all registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_UNSYNC;
      row_q      <= '0;
      idx_q      <= '0;
      discard_q  <= 1'b0;
      data_q     <= '0;
      strobe_q   <= '0;
      synced_q   <= 1'b0;
      addr_err_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      discard_q  <= discard_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      synced_q   <= synced_d;
      addr_err_q <= addr_err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    idx_d      = idx_q;
    discard_d  = discard_q;
    data_d     = data_q;
    addr_err_d = addr_err_q;
    strobe_d   = '0;

    case (state_q)
      S_UNSYNC: begin
        if (transfer && (WordData == SyncWord)) state_d = S_CMD;
      end
      S_CMD: begin
        if (transfer) begin
          if (opcode == 4'h1) begin
            idx_d     = IDX_W'(cmd_col) * IDX_W'(MaxFramesPerCol) + IDX_W'(cmd_frame);
            discard_d = out_of_range;
            if (out_of_range) addr_err_d = 1'b1;
            row_d     = '0;
            state_d   = S_DATA;
          end else if (opcode == 4'hF) begin
            state_d = S_UNSYNC;
          end
        end
      end
      S_DATA: begin
        if (transfer) begin
          for (int r = 0; r < int'(NumberOfRows); r++) begin
            if (row_q == ROW_W'(r)) data_d[32*r +: 32] = WordData;
          end
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_W'(NumberOfRows - 1)) state_d = discard_q ? S_CMD : S_STROBE;
        end
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_CMD;
      default:  state_d = S_UNSYNC;
    endcase

    if (state_d == S_STROBE) strobe_d = STRB_W'(1) << idx_q;
    ready_d  = (state_d != S_STROBE) && (state_d != S_HOLD);
    busy_d   = (state_d == S_DATA) || (state_d == S_STROBE) || (state_d == S_HOLD);
    synced_d = (state_d != S_UNSYNC);
  end

  assign WordReady   = ready_q;
  assign FrameData   = data_q;
  // A reset landing on the strobe cycle must kill the pulse immediately.
  assign FrameStrobe = reset ? STRB_W'(0) : strobe_q;
  assign Synced      = synced_q;
  assign AddrError   = addr_err_q;
  assign Busy        = busy_q;

endmodule
